// File: rtl/image_rom_arbiter_pkg.sv
// rtl/image_rom_arbiter_pkg.sv - shared image geometry, pixel-address helper and ROM pattern
// Purpose: constants and helpers shared by the image ROM arbiter, its
//          round-robin picker and the image ROM.
// Ports:   none (package).
package image_rom_arbiter_pkg;

   localparam int IMG_ADDR_W = 12;
   localparam int IMG_RGB_W  = 12;
   localparam int IMG_W      = 48;
   localparam int IMG_H      = 64;

   typedef logic [IMG_ADDR_W-1:0] img_addr_t;
   typedef logic [IMG_RGB_W-1:0]  img_rgb_t;

   // ROM word address of pixel (x, y): row-major with a 64-word row pitch.
   function automatic img_addr_t pixel_addr(input logic [5:0] x, input logic [5:0] y);
      return {y, x};
   endfunction

   // Fixed picture content of the image ROM.
   function automatic img_rgb_t rom_pattern(input img_addr_t a);
      return a * 12'd37 + 12'h5a3;
   endfunction

endpackage

// File: rtl/image_rom.sv
// rtl/image_rom.sv - 4096 x 12-bit synchronous-read image ROM
// Purpose: holds the picture; data appears one clock after the address.
// Ports:   clk     - system clock
//          address - word address {y[5:0], x[5:0]}
//          rgb     - registered read data {r, g, b}
module image_rom
   import image_rom_arbiter_pkg::*;
(
   input  logic      clk,
   input  img_addr_t address,
   output img_rgb_t  rgb
);

   always_ff @(posedge clk) begin
      rgb <= rom_pattern(address);
   end

endmodule

// File: rtl/image_rom_arbiter_rr_pick.sv
// rtl/image_rom_arbiter_rr_pick.sv - combinational round-robin picker
// Purpose: picks the first set request searching upward from ptr with wrap.
// Ports:   req   - request vector
//          ptr   - index with highest priority this cycle
//          grant - one-hot grant, zero when no request is set
module image_rom_arbiter_rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   // One spare bit so ptr + k never overflows before the modulo-N fold.
   logic [PTR_W:0] idx;
   logic           found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(N)) begin
            idx = idx - (PTR_W+1)'(N);
         end
         if (!found && req[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/image_rom_arbiter.sv
// rtl/image_rom_arbiter.sv - round-robin sharing of the image ROM between pixel fetchers
// Purpose: grants one fetch per clock, registers the ROM address and returns
//          each word two edges after the accept with a one-hot tag.
// Ports:   clk, rst     - clock, synchronous active-high reset
//          req_valid    - per-requester request strobe
//          req_addr     - flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//          req_ready    - one-hot combinational grant
//          rom_address  - registered ROM address
//          rom_rgb      - ROM read data
//          rsp_valid    - one-hot response tag
//          rsp_rgb      - response pixel
module image_rom_arbiter
   import image_rom_arbiter_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = IMG_ADDR_W,
   parameter int RGB_W  = IMG_RGB_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]       rom_address,
   input  logic [RGB_W-1:0]        rom_rgb,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [RGB_W-1:0]        rsp_rgb
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_nxt;
   logic [PTR_W-1:0]  grant_idx;
   logic [N_REQ-1:0]  grant;
   logic [N_REQ-1:0]  tag_s1;
   logic [ADDR_W-1:0] sel_addr;
   logic              accept;

   image_rom_arbiter_rr_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   // The picker only grants valid requesters, so any ready bit is an accept.
   assign req_ready = rst ? '0 : grant;
   assign accept    = |req_ready;

   always_comb begin
      grant_idx = '0;
      sel_addr  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_W'(i);
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
      ptr_nxt = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
   end

   // The ROM registers its data, so the tag needs two stages to line up with rom_rgb.
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_address <= '0;
         tag_s1      <= '0;
         rsp_valid   <= '0;
         ptr         <= '0;
      end else begin
         tag_s1    <= req_ready;
         rsp_valid <= tag_s1;
         if (accept) begin
            rom_address <= sel_addr;
            ptr         <= ptr_nxt;
         end
      end
   end

   assign rsp_rgb = rom_rgb;

endmodule
